cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//  Multi-cycle control sequencer for the 10-bit CPU datapath. On start it loads the
//  instruction register (IR, a 10-bit enabled register) and decodes the IR contents.
//  It then steps through 1 or 3 execute cycles, driving the per-register load enables,
//  the bus source select, the accumulator A / result G enables and the ALU op.
//  It sits directly upstream of every datapath register: its enables feed their en inputs.
// PARAMETERS
//  DATA_W    10  instruction/datapath width; IR fields below are fixed for DATA_W=10
//  NUM_REGS  4   general registers R0..R3; rin width, 2-bit register fields
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high; FSM -> IDLE, all outputs 0
//  start     in   1   request to execute the word currently on the instruction input
//  ir        in   10  IR register output; opcode=ir[9:6], rx=ir[5:4], ry=ir[3:2], ir[1:0] ignored
//  ir_en     out  1   IR load enable
//  rin       out  4   one-hot load enable for R0..R3
//  bus_sel   out  3   bus source: 0-3=R0-R3, 4=EXT data, 5=G, others unused
//  a_en      out  1   load accumulator A from bus
//  g_en      out  1   load G from ALU (A op bus)
//  alu_op    out  2   0=ADD 1=SUB 2=XOR
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse in DONE
//  illegal   out  1   high with done when opcode was undefined
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from state + ir, registered state only, no output glitches on start.
//  - States: IDLE, FETCH, EXEC1, EXEC2, EXEC3, DONE.
//  - IDLE: start=1 -> FETCH; else stay. start is sampled only in IDLE; it is ignored in all other states.
//  - FETCH: ir_en=1 (IR captures at end of cycle) -> EXEC1. ir is valid from EXEC1 onward.
//  - Opcodes: 0000 LOAD rx<-EXT; 0001 MOV rx<-ry; 0010 ADD, 0011 SUB, 0100 XOR: rx<-rx op ry;
//    0101-1111 illegal.
//  - LOAD  EXEC1: bus_sel=4, rin[rx]=1 -> DONE.
//  - MOV   EXEC1: bus_sel=ry, rin[rx]=1 -> DONE. MOV rx==ry is a legal no-op write.
//  - ALU   EXEC1: bus_sel=rx, a_en=1 -> EXEC2; EXEC2: bus_sel=ry, g_en=1, alu_op per opcode -> EXEC3;
//          EXEC3: bus_sel=5, rin[rx]=1 -> DONE.
//  - Illegal EXEC1: no enables asserted -> DONE; illegal=1 during DONE only.
//  - DONE: done=1 for exactly one cycle -> IDLE unconditionally. start held high across DONE is
//    sampled in IDLE on the following cycle, so back-to-back instructions are spaced 1 IDLE cycle apart.
//  - Latency from the start-sampling edge to done: LOAD/MOV/illegal 3 cycles, ALU 5 cycles.
//  - Inactive defaults: rin=0, bus_sel=0, alu_op=0, all enables 0.
//  - At most one rin bit is high in any cycle. ir_en, a_en, g_en and rin never overlap in one cycle.
//  - Reset mid-instruction aborts immediately, with no partial write after reset deasserts.
//    First cycle after release: IDLE, outputs 0. start high at release is honoured on the first edge.
// STRUCTURE
//  - cpu_pkg: opcode localparams, state encoding, bus_sel codes, alu_op codes, IR field
//    positions; shared with the datapath mux and ALU.
//  - Sub-module dec2to4: 2-bit to one-hot decoder with enable, producing rin.
//  - Everything else is in one next-state always block plus one output-decode block.
// TESTING
//  1 Reset: assert reset mid-ALU EXEC2 -> next sample IDLE, rin=0, g_en=0, busy=0; no R write after release.
//  2 LOAD: ir=10'b0000_10_00_00, start 1 cycle -> FETCH ir_en=1; EXEC1 bus_sel=4, rin=4'b0100;
//    done 3 cycles after start.
//  3 ADD R1,R3: ir=10'b0010_01_11_00 -> EXEC1 bus_sel=1,a_en; EXEC2 bus_sel=3,g_en,alu_op=0;
//    EXEC3 bus_sel=5,rin=4'b0010; done at +5.
//  4 Illegal: ir=10'b1111_00_00_00 -> no rin/a_en/g_en pulse; done=1 and illegal=1 at +3 only.
//  5 start held high continuously with MOV R0,R2: done every 4 cycles. start pulse during EXEC1 is ignored.
//  6 Assertion throughout: $onehot0(rin); done width 1; busy==0 iff IDLE; SUB/XOR alu_op=1/2 in EXEC2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 10-bit CPU: IR layout, opcodes, FSM states, bus and ALU codes.
package cpu_pkg;

  localparam int unsigned DATA_W    = 10;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned REG_W     = 2;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned BUS_SEL_W = 3;
  localparam int unsigned ALU_OP_W  = 2;

  // IR field layout: opcode[9:6], rx[5:4], ry[3:2], pad[1:0]
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;
    logic [1:0]       pad;
  } instr_t;

  localparam logic [OPC_W-1:0] OP_LOAD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b0100;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC1 = 3'd2;
  localparam logic [STATE_W-1:0] S_EXEC2 = 3'd3;
  localparam logic [STATE_W-1:0] S_EXEC3 = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

  localparam logic [BUS_SEL_W-1:0] BUS_EXT = 3'd4;
  localparam logic [BUS_SEL_W-1:0] BUS_G   = 3'd5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 2'd2;

  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_dec2to4.sv
// 2-bit to one-hot decoder with enable; drives the general-register load enables.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y = 4'b0001 << sel;
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 10-bit datapath: fetch, decode, 1 or 3 execute
// cycles, done. Outputs are a Moore decode of the state register and the IR contents.
module cpu_control_fsm
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    ir,
  output logic                 ir_en,
  output logic [NUM_REGS-1:0]  rin,
  output logic [BUS_SEL_W-1:0] bus_sel,
  output logic                 a_en,
  output logic                 g_en,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  instr_t             word;
  logic               rin_en;
  logic [REG_W-1:0]   rin_sel;
  logic               unused_ir_pad;

  assign word          = instr_t'(ir);
  assign unused_ir_pad = ^word.pad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start only matters in IDLE; DONE always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC1;
      S_EXEC1: state_nxt = is_alu(word.opcode) ? S_EXEC2 : S_DONE;
      S_EXEC2: state_nxt = S_EXEC3;
      S_EXEC3: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; IR fields are only trusted from EXEC1 onward
  always_comb begin
    ir_en   = 1'b0;
    rin_en  = 1'b0;
    rin_sel = '0;
    bus_sel = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    alu_op  = ALU_ADD;
    busy    = (state != S_IDLE);
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      S_FETCH: ir_en = 1'b1;
      S_EXEC1: begin
        case (word.opcode)
          OP_LOAD: begin
            bus_sel = BUS_EXT;
            rin_en  = 1'b1;
            rin_sel = word.rx;
          end
          OP_MOV: begin
            bus_sel = BUS_SEL_W'(word.ry);
            rin_en  = 1'b1;
            rin_sel = word.rx;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            bus_sel = BUS_SEL_W'(word.rx);
            a_en    = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        bus_sel = BUS_SEL_W'(word.ry);
        g_en    = 1'b1;
        alu_op  = alu_op_of(word.opcode);
      end
      S_EXEC3: begin
        bus_sel = BUS_G;
        rin_en  = 1'b1;
        rin_sel = word.rx;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = ~is_legal(word.opcode);
      end
      default: ;
    endcase
  end

  dec2to4 u_rin_dec (
    .en  (rin_en),
    .sel (rin_sel),
    .y   (rin)
  );

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: a behavioural datapath follows the FSM's enables, and each finished
// instruction is checked against an architectural register-file model.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] ir_q;
  logic       ir_en;
  logic [3:0] rin;
  logic [2:0] bus_sel;
  logic       a_en;
  logic       g_en;
  logic [1:0] alu_op;
  logic       busy;
  logic       done;
  logic       illegal;

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ir      (ir_q),
    .ir_en   (ir_en),
    .rin     (rin),
    .bus_sel (bus_sel),
    .a_en    (a_en),
    .g_en    (g_en),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Datapath driven purely by the FSM's enables
  logic             dp_init;
  logic [9:0]       ins;
  logic [9:0]       ext;
  logic [3:0][9:0]  dreg;
  logic [9:0]       a_r;
  logic [9:0]       g_r;
  logic [9:0]       bus;

  always_comb begin
    case (bus_sel)
      3'd0, 3'd1, 3'd2, 3'd3: bus = dreg[bus_sel[1:0]];
      3'd4:                   bus = ext;
      3'd5:                   bus = g_r;
      default:                bus = 10'h000;
    endcase
  end

  always @(posedge clk) begin
    if (dp_init) begin
      dreg <= '0;
      a_r  <= '0;
      g_r  <= '0;
      ir_q <= '0;
    end else begin
      if (ir_en) ir_q <= ins;
      if (a_en)  a_r  <= bus;
      if (g_en) begin
        case (alu_op)
          2'd0:    g_r <= a_r + bus;
          2'd1:    g_r <= a_r - bus;
          2'd2:    g_r <= a_r ^ bus;
          default: g_r <= 10'h3ff;
        endcase
      end
      for (int i = 0; i < 4; i++) if (rin[i]) dreg[i] <= bus;
    end
  end

  typedef struct {
    int              issue;
    int              lat;
    logic            ill;
    logic [3:0][9:0] r;
  } exp_t;

  exp_t            sb[$];
  logic [3:0][9:0] mreg;

  // Architectural effect of one instruction on the register file
  task automatic model_step(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                            input logic [9:0] e, input int issue_cyc);
    exp_t x;
    case (op)
      4'd0:    mreg[rx] = e;
      4'd1:    mreg[rx] = mreg[ry];
      4'd2:    mreg[rx] = mreg[rx] + mreg[ry];
      4'd3:    mreg[rx] = mreg[rx] - mreg[ry];
      4'd4:    mreg[rx] = mreg[rx] ^ mreg[ry];
      default: ;
    endcase
    x.issue = issue_cyc;
    x.lat   = (op >= 4'd2 && op <= 4'd4) ? 5 : 3;
    x.ill   = (op > 4'd4);
    x.r     = mreg;
    sb.push_back(x);
  endtask

  // Monitor: per-cycle invariants, and scoreboard compare on every done
  logic prev_done = 1'b0;
  int   busy_run  = 0;

  always @(negedge clk) begin
    if (reset || dp_init) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      chk("rin_onehot0", 32'($onehot0(rin)), 32'd1);
      chk("enable_overlap", 32'((32'(ir_en) + 32'(a_en) + 32'(g_en) + 32'(rin != 4'd0)) <= 32'd1), 32'd1);
      chk("illegal_without_done", 32'(illegal & ~done), 32'd0);
      chk("done_width", 32'(done & prev_done), 32'd0);
      chk("idle_quiet", 32'(~busy & (ir_en | a_en | g_en | (rin != 4'd0) | done)), 32'd0);
      busy_run = busy ? busy_run + 1 : 0;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("busy_cycles", 32'(busy_run), 32'(e.lat));
          chk("illegal_flag", 32'(illegal), 32'(e.ill));
          for (int i = 0; i < 4; i++) chk($sformatf("reg_R%0d", i), 32'(dreg[i]), 32'(e.r[i]));
        end
      end
      prev_done = done;
    end
  end

  // Called in an IDLE cycle just after a rising edge; returns one cycle later (FETCH)
  task automatic issue(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [9:0] e, input logic noise);
    logic [1:0] pad;
    pad   = 2'($urandom_range(0, 3));
    ins   = {op, rx, ry, pad};
    ext   = e;
    start = 1'b1;
    model_step(op, rx, ry, e, cyc);
    @(posedge clk); #1 start = 1'b0;
    if (noise) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic alu_phases(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry);
    issue(op, rx, ry, 10'($urandom), 1'b0);
    @(negedge clk);
    chk("alu_fetch_ir_en", 32'(ir_en), 32'd1);
    @(negedge clk);
    chk("alu_e1_bus_sel", 32'(bus_sel), 32'(rx));
    chk("alu_e1_a_en", 32'(a_en), 32'd1);
    @(negedge clk);
    chk("alu_e2_bus_sel", 32'(bus_sel), 32'(ry));
    chk("alu_e2_g_en", 32'(g_en), 32'd1);
    chk("alu_e2_alu_op", 32'(alu_op), 32'(op - 4'd2));
    @(negedge clk);
    chk("alu_e3_bus_sel", 32'(bus_sel), 32'd5);
    chk("alu_e3_rin", 32'(rin), 32'(4'b0001 << rx));
    wait_idle();
  endtask

  // start held high: a new MOV R0,R2 every 4 cycles
  task automatic held_mov(input int n);
    int k;
    ins   = {4'b0001, 2'd0, 2'd2, 2'b00};
    start = 1'b1;
    k     = cyc;
    for (int i = 0; i < n; i++) model_step(4'd1, 2'd0, 2'd2, ext, k + 4 * i);
    repeat (4 * (n - 1) + 1) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
  endtask

  task automatic random_ops(input int n);
    logic [3:0] op;
    int         gap;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 10'($urandom),
            1'($urandom_range(0, 1)));
      wait_idle();
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    dp_init = 1'b1;
    start   = 1'b0;
    ins     = '0;
    ext     = '0;
    mreg    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_enables", 32'({ir_en, a_en, g_en}), 32'd0);
    chk("reset_rin", 32'(rin), 32'd0);
    chk("reset_bus_sel", 32'(bus_sel), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    dp_init = 1'b0;
    @(posedge clk); #1;

    // LOAD R2 <- EXT
    issue(4'd0, 2'd2, 2'd0, 10'h2a5, 1'b0);
    @(negedge clk);
    chk("load_fetch_ir_en", 32'(ir_en), 32'd1);
    @(negedge clk);
    chk("load_e1_bus_sel", 32'(bus_sel), 32'd4);
    chk("load_e1_rin", 32'(rin), 32'b0100);
    wait_idle();

    issue(4'd0, 2'd1, 2'd0, 10'h155, 1'b0);
    wait_idle();
    issue(4'd0, 2'd3, 2'd0, 10'h3c7, 1'b1);
    wait_idle();

    alu_phases(4'd2, 2'd1, 2'd3);
    alu_phases(4'd3, 2'd0, 2'd1);
    alu_phases(4'd4, 2'd3, 2'd2);
    alu_phases(4'd2, 2'd2, 2'd2);

    // Illegal opcode: nothing enabled in EXEC1
    issue(4'd15, 2'd0, 2'd0, 10'h0ff, 1'b0);
    @(negedge clk);
    chk("ill_fetch_ir_en", 32'(ir_en), 32'd1);
    @(negedge clk);
    chk("ill_e1_enables", 32'({rin, a_en, g_en}), 32'd0);
    chk("ill_e1_flags", 32'({illegal, done}), 32'd0);
    wait_idle();

    held_mov(4);
    random_ops(60);

    // Reset during ADD EXEC2, with start held so the release edge takes a LOAD
    ins   = {4'b0010, 2'd1, 2'd3, 2'b00};
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    ins   = {4'b0000, 2'd3, 2'd0, 2'b00};
    ext   = 10'h0a9;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rin", 32'(rin), 32'd0);
    chk("abort_g_en", 32'(g_en), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_step(4'd0, 2'd3, 2'd0, 10'h0a9, cyc);
    @(negedge clk);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_outputs", 32'({ir_en, rin, bus_sel, a_en, g_en, alu_op, done, illegal}), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    random_ops(20);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
